// File: rtl/tx_ctrl_pkg.sv
// Shared types and constants for the 64b/66b transmit sequencing controller.
package tx_ctrl_pkg;

    // Controller states; encodings are visible on o_state.
    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_WAIT_READY = 2'd1,
        ST_INIT_WAIT  = 2'd2,
        ST_RUN        = 2'd3
    } tx_state_t;

    localparam int REINIT_COUNT_W = 8;

    // The gearbox cadence only runs while the encoder is out of reset.
    function automatic logic is_active(input tx_state_t s);
        return (s == ST_INIT_WAIT) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/tx_ready_filter.sv
// Consecutive-high filter for the serdes ready flag. locked asserts on the
// cycle whose edge would bring the run of highs up to LOCK_FILTER, so the
// owner can change state on that same edge.
module tx_ready_filter #(
    parameter int LOCK_FILTER = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic in,
    output logic locked
);

    localparam int CW = $clog2(LOCK_FILTER + 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    // Count consecutive highs, saturating at LOCK_FILTER; any low or clear restarts.
    always_comb begin
        count_next = count_reg;
        if (clear || !in) begin
            count_next = '0;
        end else if (count_reg != CW'(LOCK_FILTER)) begin
            count_next = count_reg + 1'b1;
        end
    end

    // Filter count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign locked = (count_next == CW'(LOCK_FILTER));

endmodule

// File: rtl/tx_encode_ctrl.sv
// Sequencing controller for the 64b/66b TX encoder and gearbox: releases the
// encoder once serdes TX is ready, holds an init period, then runs the
// gearbox pause cadence and tells the MAC when a word is accepted.
// Optional build macro TX_CTRL_PAUSE_LOOKAHEAD_EN adds o_pause_next and
// masks o_mac_ready one cycle ahead of each pause.
module tx_encode_ctrl
    import tx_ctrl_pkg::*;
#(
    parameter int PAUSE_PERIOD     = 32,
    parameter int INIT_WAIT_CYCLES = 64,
    parameter int LOCK_FILTER      = 4
) (
    input  logic                               i_txc,
    input  logic                               i_reset,
    input  logic                               i_serdes_ready,
    input  logic                               i_force_reinit,
    output logic                               o_encoder_reset,
    output logic                               o_init_done,
    output logic                               o_tx_pause,
    output logic                               o_mac_ready,
    output logic [$clog2(PAUSE_PERIOD+1)-1:0]  o_gearbox_seq,
    output logic [1:0]                         o_state,
    output logic [REINIT_COUNT_W-1:0]          o_reinit_count
`ifdef TX_CTRL_PAUSE_LOOKAHEAD_EN
    ,
    output logic                               o_pause_next
`endif
);

    localparam int SW = $clog2(PAUSE_PERIOD + 1);
    localparam int IW = $clog2(INIT_WAIT_CYCLES + 1);

    tx_state_t                 state_reg, state_next;
    logic [IW-1:0]             init_cnt_reg, init_cnt_next;
    logic [SW-1:0]             seq_reg, seq_next;
    logic [REINIT_COUNT_W-1:0] reinit_reg, reinit_next;
    logic                      locked;
    logic                      drop;
    logic                      pause;

    tx_ready_filter #(
        .LOCK_FILTER (LOCK_FILTER)
    ) u_ready_filter (
        .clk    (i_txc),
        .reset  (i_reset),
        .clear  (state_reg != ST_WAIT_READY),
        .in     (i_serdes_ready),
        .locked (locked)
    );

    // Ready loss and a forced reinit are one event; either restarts the sequence.
    assign drop = !i_serdes_ready || i_force_reinit;

    // Next-state, init counter, gearbox cadence and reinit counter.
    always_comb begin
        state_next    = state_reg;
        init_cnt_next = '0;
        seq_next      = '0;
        reinit_next   = reinit_reg;

        case (state_reg)
            ST_RESET_HOLD: state_next = ST_WAIT_READY;
            ST_WAIT_READY: begin
                // A low ready here only restarts the filter.
                if (i_force_reinit) begin
                    state_next = ST_RESET_HOLD;
                end else if (locked) begin
                    state_next = ST_INIT_WAIT;
                end
            end
            ST_INIT_WAIT: begin
                if (drop) begin
                    state_next = ST_RESET_HOLD;
                end else if (init_cnt_reg == IW'(INIT_WAIT_CYCLES - 1)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (drop) begin
                    state_next = ST_RESET_HOLD;
                end
            end
            default: state_next = ST_RESET_HOLD;
        endcase

        if (state_reg == ST_INIT_WAIT && state_next == ST_INIT_WAIT) begin
            init_cnt_next = init_cnt_reg + 1'b1;
        end

        // Cadence restarts at 0 on entry to INIT_WAIT and carries into RUN.
        if (is_active(state_reg) && is_active(state_next)) begin
            seq_next = (seq_reg == SW'(PAUSE_PERIOD)) ? '0 : seq_reg + 1'b1;
        end

        if (state_reg == ST_RUN && state_next == ST_RESET_HOLD && reinit_reg != '1) begin
            reinit_next = reinit_reg + 1'b1;
        end
    end

    // State and counter registers.
    always_ff @(posedge i_txc or posedge i_reset) begin
        if (i_reset) begin
            state_reg    <= ST_RESET_HOLD;
            init_cnt_reg <= '0;
            seq_reg      <= '0;
            reinit_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
            seq_reg      <= seq_next;
            reinit_reg   <= reinit_next;
        end
    end

    // Outputs decode registered state only, so no input reaches them combinationally.
    assign pause           = is_active(state_reg) && (seq_reg == SW'(PAUSE_PERIOD));
    assign o_tx_pause      = pause;
    assign o_encoder_reset = (state_reg == ST_RESET_HOLD) || (state_reg == ST_WAIT_READY);
    assign o_init_done     = (state_reg == ST_RUN);
    assign o_gearbox_seq   = seq_reg;
    assign o_state         = state_reg;
    assign o_reinit_count  = reinit_reg;

`ifdef TX_CTRL_PAUSE_LOOKAHEAD_EN
    logic pause_ahead;
    assign pause_ahead  = is_active(state_reg) && (seq_reg == SW'(PAUSE_PERIOD - 1));
    assign o_pause_next = pause_ahead;
    assign o_mac_ready  = (state_reg == ST_RUN) && !pause && !pause_ahead;
`else
    assign o_mac_ready  = (state_reg == ST_RUN) && !pause;
`endif

endmodule

// File: tb/tb_tx_encode_ctrl.sv
// Directed self-checking bench for tx_encode_ctrl (default parameters).
// Build with TX_CTRL_PAUSE_LOOKAHEAD_EN to also cover the lookahead output.
module tb_tx_encode_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ready;
    logic       force_reinit;
    logic       enc_reset;
    logic       init_done;
    logic       tx_pause;
    logic       mac_ready;
    logic [5:0] seq;
    logic [1:0] state;
    logic [7:0] reinit_count;
`ifdef TX_CTRL_PAUSE_LOOKAHEAD_EN
    logic       pause_next;
`endif

    int checks = 0;
    int errors = 0;

    tx_encode_ctrl dut (
        .i_txc          (clk),
        .i_reset        (rst),
        .i_serdes_ready (ready),
        .i_force_reinit (force_reinit),
        .o_encoder_reset(enc_reset),
        .o_init_done    (init_done),
        .o_tx_pause     (tx_pause),
        .o_mac_ready    (mac_ready),
        .o_gearbox_seq  (seq),
        .o_state        (state),
        .o_reinit_count (reinit_count)
`ifdef TX_CTRL_PAUSE_LOOKAHEAD_EN
        ,
        .o_pause_next   (pause_next)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for RUN.
    task automatic wait_run(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (state == 2'd3) break;
            step();
        end
        chk(tag, state, 2'd3);
    endtask

    // Cadence outputs for a RUN cycle whose model sequence value is m.
    task automatic chk_cadence(input int m);
        chk("seq", seq, m);
        chk("tx_pause", tx_pause, (m == 32));
`ifdef TX_CTRL_PAUSE_LOOKAHEAD_EN
        chk("pause_next", pause_next, (m == 31));
        chk("mac_ready", mac_ready, !(m == 32 || m == 31));
`else
        chk("mac_ready", mac_ready, !(m == 32));
`endif
    endtask

    initial begin
        int m;
        int last_pause;
        int n_pause;
        int pat [8];
        int exp_cnt;

        rst = 1'b1;
        ready = 1'b1;
        force_reinit = 1'b0;
        step();
        step();

        // Reset values.
        chk("rst_state", state, 0);
        chk("rst_enc_reset", enc_reset, 1);
        chk("rst_init_done", init_done, 0);
        chk("rst_mac_ready", mac_ready, 0);
        chk("rst_tx_pause", tx_pause, 0);
        chk("rst_seq", seq, 0);
        chk("rst_reinit", reinit_count, 0);
        $display("reset values checked");

        // Bring-up: 1 cycle RESET_HOLD + 4 filtered cycles, then 64 init cycles.
        rst = 1'b0;
        step();
        chk("hold_to_wait", state, 1);
        step(); step(); step();
        chk("wait_still", state, 1);
        chk("wait_enc_reset", enc_reset, 1);
        step();
        chk("enter_init", state, 2);
        chk("init_enc_reset", enc_reset, 0);
        chk("init_seq0", seq, 0);
        chk("init_no_done", init_done, 0);
        repeat (63) step();
        chk("init_last", state, 2);
        chk("init_last_done", init_done, 0);
        chk("init_last_seq", seq, 30);
        step();
        chk("enter_run", state, 3);
        chk("run_done", init_done, 1);
        m = 31;
        chk_cadence(m);
        $display("bring-up checked, RUN entered at seq=%0d", seq);

        // Pause cadence over 99 RUN cycles.
        last_pause = -1;
        n_pause = 0;
        for (int c = 1; c <= 99; c++) begin
            step();
            m = (m + 1) % 33;
            chk_cadence(m);
            if (tx_pause === 1'b1) begin
                if (last_pause >= 0) chk("pause_spacing", c - last_pause, 33);
                last_pause = c;
                n_pause++;
            end
        end
        chk("pause_count", n_pause, 3);
        $display("cadence checked over 99 cycles, pauses=%0d", n_pause);

        // Force reinit together with ready loss: a single exit event.
        force_reinit = 1'b1;
        ready = 1'b0;
        step();
        force_reinit = 1'b0;
        chk("reinit_state", state, 0);
        chk("reinit_count1", reinit_count, 1);
        chk("reinit_done", init_done, 0);
        chk("reinit_mac", mac_ready, 0);
        chk("reinit_enc", enc_reset, 1);
        chk("reinit_seq", seq, 0);
        chk("reinit_pause", tx_pause, 0);
        step();
        chk("reinit_to_wait", state, 1);
        $display("single-event reinit checked, count=%0d", reinit_count);

        // Broken ready run in WAIT_READY: only the final 4-high run locks.
        pat = '{1, 1, 1, 0, 1, 1, 1, 1};
        for (int i = 0; i < 8; i++) begin
            ready = pat[i][0];
            step();
            chk("filter_state", state, (i == 7) ? 2 : 1);
        end
        ready = 1'b1;
        wait_run("filter_run");
        $display("ready filter pattern checked");

        // Saturation: alternate forced and ready-loss exits from RUN.
        for (int k = 0; k < 260; k++) begin
            if (k % 2 == 1) ready = 1'b0;
            else force_reinit = 1'b1;
            step();
            force_reinit = 1'b0;
            ready = 1'b1;
            chk("sat_exit_state", state, 0);
            exp_cnt = (k + 2 > 255) ? 255 : k + 2;
            chk("sat_count", reinit_count, exp_cnt);
            wait_run("sat_run");
        end
        $display("reinit counter saturation checked, count=%0d", reinit_count);

        // Asynchronous reset mid-RUN takes effect without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk("async_state", state, 0);
        chk("async_reinit", reinit_count, 0);
        chk("async_enc", enc_reset, 1);
        chk("async_mac", mac_ready, 0);
        $display("async reset checked");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
